// File: rtl/qlearn_pkg.sv
// Shared types and constants for the Q-learning datapath blocks.
package qlearn_pkg;

  localparam int NUM_ACTIONS = 15;
  localparam int Q_W         = 16;
  localparam int STATE_W     = 6;
  localparam int ACTION_W    = 4;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Q-values are signed Q8.8
  typedef logic signed [Q_W-1:0] qval_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } sel_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps only when asked to.
module lfsr16
  import qlearn_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  output logic [15:0] value
);

  logic [15:0] lfsr_q, lfsr_d;

  // next value: step once on adv, otherwise hold
  always_comb begin
    lfsr_d = adv ? lfsr_next(lfsr_q) : lfsr_q;
  end

  // state register, reset to the seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/q_action_selector.sv
// Epsilon-greedy action selector over one Q-table row.
//
// state | meaning
// IDLE  | ready; explore vs greedy decided in the accept cycle
// SCAN  | issue reads for actions 1..NUM_ACTIONS, compare data one cycle behind
// DRAIN | last datum returns; best action/value registered to the outputs
// OUT   | result presented, held until act_ready
module q_action_selector #(
  parameter int          NUM_ACTIONS = 15,
  parameter int          Q_W         = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [qlearn_pkg::STATE_W-1:0]  req_state,
  input  logic [15:0]                     epsilon,
  output logic                            q_rd_en,
  output logic [qlearn_pkg::STATE_W-1:0]  q_rd_state,
  output logic [qlearn_pkg::ACTION_W-1:0] q_rd_action,
  input  logic [Q_W-1:0]                  q_rd_data,
  output logic                            act_valid,
  input  logic                            act_ready,
  output logic [qlearn_pkg::ACTION_W-1:0] act,
  output logic [Q_W-1:0]                  act_q,
  output logic                            act_explored
);
  import qlearn_pkg::*;

  localparam logic [ACTION_W-1:0] LAST_ACT  = ACTION_W'(NUM_ACTIONS);
  localparam logic [ACTION_W-1:0] FIRST_ACT = ACTION_W'(1);

  sel_state_e            state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic [STATE_W-1:0]    rd_state_q, rd_state_d;
  logic [ACTION_W-1:0]   rd_action_q, rd_action_d;
  logic                  pend_q, pend_d;
  logic [ACTION_W-1:0]   pend_act_q, pend_act_d;
  logic signed [Q_W-1:0] best_q, best_d;
  logic [ACTION_W-1:0]   best_act_q, best_act_d;
  logic                  out_valid_q, out_valid_d;
  logic [ACTION_W-1:0]   out_act_q, out_act_d;
  logic [Q_W-1:0]        out_qval_q, out_qval_d;
  logic                  out_expl_q, out_expl_d;

  logic [15:0]           lfsr_val;
  logic                  lfsr_adv;
  logic                  take;
  logic [ACTION_W-1:0]   rnd_act;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (lfsr_adv),
    .value (lfsr_val)
  );

  // next-state, read-port sequencing and pipelined argmax
  always_comb begin
    state_d     = state_q;
    rd_en_d     = rd_en_q;
    rd_state_d  = rd_state_q;
    rd_action_d = rd_action_q;
    out_valid_d = out_valid_q;
    out_act_d   = out_act_q;
    out_qval_d  = out_qval_q;
    out_expl_d  = out_expl_q;
    lfsr_adv    = 1'b0;

    // read data belongs to the action issued last cycle; first datum seeds best,
    // later ones win only when strictly greater so ties keep the lower index
    pend_d     = rd_en_q;
    pend_act_d = rd_action_q;
    take       = pend_q && ((pend_act_q == FIRST_ACT) || ($signed(q_rd_data) > best_q));
    best_d     = take ? $signed(q_rd_data) : best_q;
    best_act_d = take ? pend_act_q : best_act_q;

    rnd_act = (lfsr_val[3:0] == 4'd0) ? FIRST_ACT : lfsr_val[ACTION_W-1:0];

    case (state_q)
      ST_IDLE: begin
        // epsilon only matters in this cycle, so no copy of it is kept
        if (req_valid) begin
          lfsr_adv = 1'b1;
          if (lfsr_val < epsilon) begin
            out_valid_d = 1'b1;
            out_act_d   = rnd_act;
            out_qval_d  = '0;
            out_expl_d  = 1'b1;
            state_d     = ST_OUT;
          end else begin
            rd_en_d     = 1'b1;
            rd_state_d  = req_state;
            rd_action_d = FIRST_ACT;
            state_d     = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (rd_action_q == LAST_ACT) begin
          rd_en_d = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          rd_action_d = rd_action_q + FIRST_ACT;
        end
      end
      ST_DRAIN: begin
        out_valid_d = 1'b1;
        out_act_d   = best_act_d;
        out_qval_d  = best_d;
        out_expl_d  = 1'b0;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (act_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      rd_state_q  <= '0;
      rd_action_q <= '0;
      pend_q      <= 1'b0;
      pend_act_q  <= '0;
      best_q      <= '0;
      best_act_q  <= '0;
      out_valid_q <= 1'b0;
      out_act_q   <= '0;
      out_qval_q  <= '0;
      out_expl_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      rd_state_q  <= rd_state_d;
      rd_action_q <= rd_action_d;
      pend_q      <= pend_d;
      pend_act_q  <= pend_act_d;
      best_q      <= best_d;
      best_act_q  <= best_act_d;
      out_valid_q <= out_valid_d;
      out_act_q   <= out_act_d;
      out_qval_q  <= out_qval_d;
      out_expl_q  <= out_expl_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign q_rd_en      = rd_en_q;
  assign q_rd_state   = rd_state_q;
  assign q_rd_action  = rd_action_q;
  assign act_valid    = out_valid_q;
  assign act          = out_act_q;
  assign act_q        = out_qval_q;
  assign act_explored = out_expl_q;

endmodule

// File: tb/tb_q_action_selector.sv
// Bench for q_action_selector: transaction-level reference model plus directed
// and randomized requests against a 64x16 Q-table with 1-cycle read latency.
module tb_q_action_selector;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_state = '0;
  logic [15:0] epsilon = '0;
  logic        q_rd_en;
  logic [5:0]  q_rd_state;
  logic [3:0]  q_rd_action;
  logic [15:0] q_rd_data = '0;
  logic        act_valid;
  logic        act_ready = 1'b0;
  logic [3:0]  act;
  logic [15:0] act_q;
  logic        act_explored;

  always #5 clk = ~clk;

  q_action_selector #(
    .NUM_ACTIONS (15),
    .Q_W         (16),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_state    (req_state),
    .epsilon      (epsilon),
    .q_rd_en      (q_rd_en),
    .q_rd_state   (q_rd_state),
    .q_rd_action  (q_rd_action),
    .q_rd_data    (q_rd_data),
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .act          (act),
    .act_q        (act_q),
    .act_explored (act_explored)
  );

  // Q-table: registered read, garbage on the data bus when nothing was read
  logic [15:0] qtab [64][16];
  always @(posedge clk) q_rd_data <= q_rd_en ? qtab[q_rd_state][q_rd_action] : 16'($urandom);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] n;
    n = {1'b0, v[15:1]};
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // largest signed value in the row, then the lowest action holding it
  function automatic logic [3:0] best_action(input logic [5:0] s);
    int mx;
    mx = -100000;
    for (int a = 1; a <= 15; a++)
      if (int'($signed(qtab[s][a])) > mx) mx = int'($signed(qtab[s][a]));
    for (int a = 1; a <= 15; a++)
      if (int'($signed(qtab[s][a])) == mx) return 4'(a);
    return 4'd0;
  endfunction

  int          cyc = 0;
  int          d_cyc;
  bit          m_busy = 1'b0;
  int          acc_cyc = 0;
  int          hs_cyc = 0;
  int          n_acc = 0;
  int          m_lat = 0;
  int          obs_lat = -1;
  logic [3:0]  m_act;
  logic [15:0] m_q;
  logic        m_expl;
  logic [5:0]  m_st;
  logic [15:0] m_lfsr = SEED;
  logic [15:0] r_smp;
  logic [3:0]  last_act;
  logic [15:0] last_q;
  logic        last_expl;
  int          last_lat;

  // single compare process, sampling mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_act_valid", act_valid, 0);
      chk("rst_act", act, 0);
      chk("rst_act_q", act_q, 0);
      chk("rst_act_explored", act_explored, 0);
      chk("rst_q_rd_en", q_rd_en, 0);
      chk("rst_q_rd_state", q_rd_state, 0);
      chk("rst_q_rd_action", q_rd_action, 0);
      m_busy = 1'b0;
      m_lfsr = SEED;
    end else if (m_busy) begin
      d_cyc = cyc - acc_cyc;
      chk("busy_req_ready", req_ready, 0);
      chk("act_valid_timing", act_valid, 32'(d_cyc >= m_lat));
      chk("q_rd_en_window", q_rd_en, 32'(!m_expl && d_cyc >= 1 && d_cyc <= 15));
      if (!m_expl && d_cyc >= 1 && d_cyc <= 15) begin
        chk("q_rd_action_seq", q_rd_action, 32'(d_cyc));
        chk("q_rd_state_row", q_rd_state, m_st);
      end
      if (act_valid && obs_lat < 0) obs_lat = d_cyc;
      if (d_cyc >= m_lat) begin
        chk("act", act, m_act);
        chk("act_q", act_q, m_q);
        chk("act_explored", act_explored, m_expl);
        if (act_ready) begin
          m_busy    = 1'b0;
          hs_cyc    = cyc;
          last_act  = act;
          last_q    = act_q;
          last_expl = act_explored;
          last_lat  = obs_lat;
        end
      end
    end else begin
      chk("idle_req_ready", req_ready, 1);
      chk("idle_act_valid", act_valid, 0);
      chk("idle_q_rd_en", q_rd_en, 0);
      if (req_valid) begin
        r_smp   = m_lfsr;
        m_lfsr  = lfsr_step(m_lfsr);
        m_st    = req_state;
        acc_cyc = cyc;
        obs_lat = -1;
        n_acc++;
        m_busy  = 1'b1;
        if (r_smp < epsilon) begin
          m_expl = 1'b1;
          m_act  = (r_smp[3:0] == 4'd0) ? 4'd1 : r_smp[3:0];
          m_q    = 16'h0000;
          m_lat  = 1;
        end else begin
          m_expl = 1'b0;
          m_act  = best_action(req_state);
          m_q    = qtab[req_state][m_act];
          m_lat  = 17;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  bit stall_force = 1'b0;
  int ready_pct = 100;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      act_ready = stall_force ? 1'b0 : (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [5:0] s, input logic [15:0] e);
    bit ok;
    ok        = 1'b0;
    req_state = s;
    epsilon   = e;
    req_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    req_state = 6'($urandom);
    epsilon   = 16'($urandom);
    chk("req_accepted", ok, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (m_busy && n < 300) begin
      tick();
      n++;
    end
    chk("txn_complete", m_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int acc_before;
    int n;
    logic [15:0] v;
    logic [5:0]  s;

    for (int i = 0; i < 64; i++)
      for (int a = 0; a < 16; a++) qtab[i][a] = 16'($urandom);

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // explore: seed ACE1 -> r[3:0]=1; then E270 -> 0 maps to 1; then 7138 -> 8
    do_req(6'd3, 16'hFFFF);
    wait_done();
    chk("lit_lfsr_after_one", m_lfsr, 16'hE270);
    chk("lit_explore1_act", last_act, 4'd1);
    chk("lit_explore1_q", last_q, 16'h0000);
    chk("lit_explore1_expl", last_expl, 1);
    chk("lit_explore1_lat", last_lat, 1);
    do_req(6'd4, 16'hFFFF);
    wait_done();
    chk("lit_explore2_act", last_act, 4'd1);
    do_req(6'd4, 16'hFFFF);
    wait_done();
    chk("lit_explore3_act", last_act, 4'd8);
    chk("lit_explore3_lat", last_lat, 1);

    // greedy ascending row
    for (int a = 0; a < 16; a++) qtab[5][a] = 16'(a * 256);
    qtab[5][0] = 16'h7FFF;
    do_req(6'd5, 16'h0000);
    wait_done();
    chk("lit_greedy_act", last_act, 4'd15);
    chk("lit_greedy_q", last_q, 16'h0F00);
    chk("lit_greedy_expl", last_expl, 0);
    chk("lit_greedy_lat", last_lat, 17);

    // tie at +2.0 on actions 4 and 9, everything else -1.0
    for (int a = 0; a < 16; a++) qtab[12][a] = 16'hFF00;
    qtab[12][4] = 16'h0200;
    qtab[12][9] = 16'h0200;
    do_req(6'd12, 16'h0000);
    wait_done();
    chk("lit_tie_act", last_act, 4'd4);
    chk("lit_tie_q", last_q, 16'h0200);

    for (int a = 0; a < 16; a++) qtab[13][a] = 16'hFF00;
    do_req(6'd13, 16'h0000);
    wait_done();
    chk("lit_allneg_act", last_act, 4'd1);
    chk("lit_allneg_q", last_q, 16'hFF00);

    // backpressure with a request pending behind the held result
    stall_force = 1'b1;
    tick();
    tick();
    do_req(6'd7, 16'hFFFF);
    n = 0;
    while (!act_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_valid_seen", act_valid, 1);
    acc_before = n_acc;
    req_state  = 6'd5;
    epsilon    = 16'h0000;
    req_valid  = 1'b1;
    repeat (10) tick();
    chk("bp_no_accept_while_held", n_acc, acc_before);
    stall_force = 1'b0;
    n = 0;
    while (n_acc == acc_before && n < 50) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
    chk("bp_accept_after_release", acc_cyc - hs_cyc, 1);
    wait_done();
    chk("lit_bp_greedy_act", last_act, 4'd15);

    // reset in SCAN cycle 7, then a clean greedy request on the same row
    for (int a = 0; a < 16; a++) qtab[20][a] = 16'(a * 16);
    qtab[20][11] = 16'h7000;
    do_req(6'd20, 16'h0000);
    repeat (6) tick();
    chk("pre_reset_scan_active", q_rd_en, 1);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    do_req(6'd20, 16'h0000);
    wait_done();
    chk("lit_post_reset_act", last_act, 4'd11);
    chk("lit_post_reset_q", last_q, 16'h7000);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      ready_pct = int'($urandom_range(30, 100));
      s = 6'($urandom);
      for (int a = 0; a < 16; a++) begin
        case ($urandom_range(0, 5))
          0:       v = 16'hFF00;
          1:       v = 16'h8000;
          2:       v = 16'h7FFF;
          3:       v = 16'h0100;
          default: v = 16'($urandom);
        endcase
        qtab[s][a] = v;
      end
      case ($urandom_range(0, 4))
        0:       v = 16'h0000;
        1:       v = 16'hFFFF;
        2:       v = 16'($urandom);
        3:       v = m_lfsr;
        default: v = m_lfsr + 16'd1;
      endcase
      do_req(s, v);
      wait_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
